framer: RTL and testbench

Transmit-side byte-stream framer. It takes an AXI4-Stream packet and emits a framed byte stream: START_BYTE, then the payload with escape stuffing, then STOP_BYTE. It sits between a packet source and a byte transport (e.g. UART TX) and produces the exact format consumed by the receive-side deframer.

---
 rtl/framer.sv | 105 ++++++++++
 tb/tb_framer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/framer.sv
// Transmit-side byte-stream framer: wraps each AXI4-Stream packet in START/STOP
// markers and escape-stuffs any payload byte that collides with a control byte.
module framer (
  input  logic       aclk,
  input  logic       areset,
  input  logic       target_tvalid,
  output logic       target_tready,
  input  logic [7:0] target_tdata,
  input  logic       target_tlast,
  output logic       initiator_tvalid,
  input  logic       initiator_tready,
  output logic [7:0] initiator_tdata
);

  localparam logic [7:0] START_BYTE  = 8'h7D;
  localparam logic [7:0] STOP_BYTE   = 8'h7E;
  localparam logic [7:0] ESCAPE_BYTE = 8'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BYTE,
    ST_ESC,
    ST_STOP
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_tvalid;
  logic [7:0] r_tdata;
  logic       w_load;
  logic       w_special;
  logic       w_emit;
  logic [7:0] w_data_next;
  logic       w_accept;

  assign w_load    = !r_tvalid || initiator_tready;
  assign w_special = (target_tdata == START_BYTE) ||
                     (target_tdata == STOP_BYTE)  ||
                     (target_tdata == ESCAPE_BYTE);

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    w_emit       = 1'b0;
    w_data_next  = r_tdata;
    w_accept     = 1'b0;
    if (w_load) begin
      unique case (r_state)
        ST_IDLE: begin
          if (target_tvalid) begin
            w_emit       = 1'b1;
            w_data_next  = START_BYTE;
            w_state_next = ST_BYTE;
          end
        end
        ST_BYTE: begin
          if (target_tvalid) begin
            w_emit = 1'b1;
            if (w_special) begin
              // The colliding byte stays on the input and is sent from ESC next.
              w_data_next  = ESCAPE_BYTE;
              w_state_next = ST_ESC;
            end else begin
              w_data_next  = target_tdata;
              w_accept     = 1'b1;
              w_state_next = target_tlast ? ST_STOP : ST_BYTE;
            end
          end
        end
        ST_ESC: begin
          w_emit       = 1'b1;
          w_data_next  = target_tdata;
          w_accept     = 1'b1;
          w_state_next = target_tlast ? ST_STOP : ST_BYTE;
        end
        ST_STOP: begin
          w_emit       = 1'b1;
          w_data_next  = STOP_BYTE;
          w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state  <= ST_IDLE;
      r_tvalid <= 1'b0;
      r_tdata  <= 8'h00;
    end else if (w_load) begin
      r_state  <= w_state_next;
      r_tvalid <= w_emit;
      if (w_emit) begin
        r_tdata <= w_data_next;
      end
    end
  end

  assign target_tready    = w_accept && !areset;
  assign initiator_tvalid = r_tvalid;
  assign initiator_tdata  = r_tdata;

endmodule

// File: tb/tb_framer.sv
// Self-checking bench for framer: a packet-level framing model predicts the
// output stream, checked on every handshake, plus literal expected frames.
module tb_framer;

  logic       aclk = 1'b0;
  logic       areset;
  logic       target_tvalid;
  logic       target_tready;
  logic [7:0] target_tdata;
  logic       target_tlast;
  logic       initiator_tvalid;
  logic       initiator_tready = 1'b1;
  logic [7:0] initiator_tdata;

  framer dut (
    .aclk             (aclk),
    .areset           (areset),
    .target_tvalid    (target_tvalid),
    .target_tready    (target_tready),
    .target_tdata     (target_tdata),
    .target_tlast     (target_tlast),
    .initiator_tvalid (initiator_tvalid),
    .initiator_tready (initiator_tready),
    .initiator_tdata  (initiator_tdata)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [7:0] d;
    int         cyc;
  } ent_t;

  int         checks = 0;
  int         failures = 0;
  int         cycle = 0;
  int         acc_cnt = 0;
  logic [7:0] exp_q[$];
  ent_t       log_q[$];
  logic       tready_random = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge aclk) cycle++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic bit is_special(input logic [7:0] b);
    return (b == 8'h7D) || (b == 8'h7E) || (b == 8'h7F);
  endfunction

  // Framing rule: START, each payload byte (preceded by ESCAPE if special), STOP.
  task automatic model_frame(input logic [7:0] pkt[$]);
    exp_q.push_back(8'h7D);
    foreach (pkt[i]) begin
      if (is_special(pkt[i])) exp_q.push_back(8'h7F);
      exp_q.push_back(pkt[i]);
    end
    exp_q.push_back(8'h7E);
  endtask

  always @(posedge aclk) begin
    #1;
    initiator_tready = tready_random ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare process: every downstream handshake against the model, plus stall rules.
  always @(negedge aclk) begin
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", 32'(initiator_tvalid), 32'd1);
        check("stall_hold_data", 32'(initiator_tdata), 32'(prev_data));
      end
      if (initiator_tvalid && !initiator_tready)
        check("stall_no_accept", 32'(target_tready), 32'd0);
      if (target_tvalid && target_tready) acc_cnt++;
      if (initiator_tvalid && initiator_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got %0h expected nothing (cycle %0d)", initiator_tdata, cycle);
        end else begin
          check("stream", 32'(initiator_tdata), 32'(exp_q.pop_front()));
        end
        log_q.push_back('{initiator_tdata, cycle});
      end
      prev_stall = initiator_tvalid && !initiator_tready;
      prev_data  = initiator_tdata;
    end
  end

  task automatic wait_accept();
    int n = 0;
    @(negedge aclk);
    while (!target_tready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 200) check("accept_timeout", 32'd0, 32'd1);
    @(posedge aclk);
    #1;
  endtask

  task automatic send_packet(input logic [7:0] pkt[$]);
    model_frame(pkt);
    for (int i = 0; i < pkt.size(); i++) begin
      target_tvalid = 1'b1;
      target_tdata  = pkt[i];
      target_tlast  = (i == pkt.size() - 1);
      wait_accept();
    end
    target_tvalid = 1'b0;
    target_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge aclk);
      n++;
    end
    if (n >= 500) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  // Literal expectations: pins the model and checks gap-free output where required.
  task automatic check_log(input string name, input logic [7:0] lit[$], input bit contiguous);
    check({name, "_len"}, 32'(log_q.size()), 32'(lit.size()));
    for (int i = 0; i < lit.size() && i < log_q.size(); i++) begin
      check({name, "_byte"}, 32'(log_q[i].d), 32'(lit[i]));
      if (contiguous && i > 0)
        check({name, "_gap"}, 32'(log_q[i].cyc - log_q[i-1].cyc), 32'd1);
    end
    log_q.delete();
  endtask

  initial begin
    logic [7:0] p[$];
    logic [7:0] q[$];
    int         c0;

    areset        = 1'b1;
    target_tvalid = 1'b0;
    target_tdata  = 8'h00;
    target_tlast  = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    target_tvalid = 1'b1;
    @(negedge aclk);
    check("reset_tvalid", 32'(initiator_tvalid), 32'd0);
    check("reset_tdata", 32'(initiator_tdata), 32'd0);
    check("reset_tready", 32'(target_tready), 32'd0);
    @(posedge aclk);
    #1;
    target_tvalid = 1'b0;
    areset        = 1'b0;
    @(posedge aclk);
    #1;

    // Plain packet with latency check.
    p = '{8'h01, 8'h02, 8'h03};
    acc_cnt = 0;
    c0 = cycle;
    send_packet(p);
    drain();
    check("plain_accepts", 32'(acc_cnt), 32'd3);
    check("latency_start", 32'(log_q[0].cyc - c0), 32'd1);
    q = '{8'h7D, 8'h01, 8'h02, 8'h03, 8'h7E};
    check_log("plain", q, 1'b1);

    // Escaping all three control bytes.
    p = '{8'h7D, 8'h7E, 8'h7F, 8'h00};
    send_packet(p);
    drain();
    q = '{8'h7D, 8'h7F, 8'h7D, 8'h7F, 8'h7E, 8'h7F, 8'h7F, 8'h00, 8'h7E};
    check_log("escape", q, 1'b1);

    // Single special byte carrying tlast.
    p = '{8'h7E};
    send_packet(p);
    drain();
    q = '{8'h7D, 8'h7F, 8'h7E, 8'h7E};
    check_log("special_last", q, 1'b1);

    // Random backpressure on a 16-byte packet with 4 specials.
    tready_random = 1'b1;
    p = '{8'h00, 8'h7D, 8'h01, 8'h02, 8'h7E, 8'h03, 8'h04, 8'h05,
          8'h7F, 8'h06, 8'h07, 8'h08, 8'h7D, 8'h09, 8'h0A, 8'h0B};
    send_packet(p);
    drain();
    tready_random = 1'b0;
    @(posedge aclk);
    #1;
    q = '{8'h7D, 8'h00, 8'h7F, 8'h7D, 8'h01, 8'h02, 8'h7F, 8'h7E, 8'h03, 8'h04, 8'h05,
          8'h7F, 8'h7F, 8'h06, 8'h07, 8'h08, 8'h7F, 8'h7D, 8'h09, 8'h0A, 8'h0B, 8'h7E};
    check_log("backpressure", q, 1'b0);

    // Back-to-back packets with continuous tvalid.
    p = '{8'hAA};
    send_packet(p);
    p = '{8'hBB, 8'h7F};
    send_packet(p);
    drain();
    q = '{8'h7D, 8'hAA, 8'h7E, 8'h7D, 8'hBB, 8'h7F, 8'h7F, 8'h7E};
    check_log("b2b", q, 1'b1);

    // Reset mid-frame after 7D 11 has gone out: the frame is abandoned.
    exp_q.push_back(8'h7D);
    exp_q.push_back(8'h11);
    target_tvalid = 1'b1;
    target_tdata  = 8'h11;
    target_tlast  = 1'b0;
    wait_accept();
    target_tvalid = 1'b0;
    @(posedge aclk);
    #1;
    areset        = 1'b1;
    target_tvalid = 1'b1;
    target_tdata  = 8'h33;
    target_tlast  = 1'b1;
    @(negedge aclk);
    check("midrst_tready", 32'(target_tready), 32'd0);
    @(negedge aclk);
    check("midrst_tvalid", 32'(initiator_tvalid), 32'd0);
    check("midrst_tdata", 32'(initiator_tdata), 32'd0);
    check("midrst_tready2", 32'(target_tready), 32'd0);
    @(posedge aclk);
    #1;
    areset        = 1'b0;
    target_tvalid = 1'b0;
    target_tlast  = 1'b0;
    check("midrst_model_empty", 32'(exp_q.size()), 32'd0);
    q = '{8'h7D, 8'h11};
    check_log("aborted", q, 1'b1);
    p = '{8'h22};
    send_packet(p);
    drain();
    q = '{8'h7D, 8'h22, 8'h7E};
    check_log("after_reset", q, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
